// File: rtl/error_display_sequencer.sv
// Error-message display sequencer: latches the sensor error, scans four letter
// positions for the 7-segment decoder, optionally blinks, and holds until acknowledged.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no latched error; display dark, index 00
// SCAN  | error latched; rotating through positions 0..3, blink optional
module error_display_sequencer #(
   parameter int DIV_SCAN     = 50000,
   parameter int BLINK_FRAMES = 250
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       erro_sensor,
   input  logic       ack,
   output logic       saida1Contador,
   output logic       saida2Contador,
   output logic [3:0] digito_en,
   output logic       erro_ativo
);

   localparam int PW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
   localparam int FW = (BLINK_FRAMES > 0) ? (($clog2(BLINK_FRAMES + 1) > 0) ? $clog2(BLINK_FRAMES + 1) : 1) : 1;
   localparam logic [PW-1:0] PRESC_TC = PW'(DIV_SCAN - 1);
   localparam logic [FW-1:0] FRAME_TC = FW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

   typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t          state, state_n;
   logic [PW-1:0]   presc, presc_n;
   logic [1:0]      idx, idx_n;
   logic [3:0]      ena, ena_n;
   logic [FW-1:0]   frame, frame_n;
   logic            phase, phase_n;
   logic [3:0]      dig, dig_n;
   logic            ativo, ativo_n;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         presc <= '0;
         idx   <= 2'b00;
         ena   <= 4'b0001;
         frame <= '0;
         phase <= 1'b0;
         dig   <= 4'b0000;
         ativo <= 1'b0;
      end else begin
         state <= state_n;
         presc <= presc_n;
         idx   <= idx_n;
         ena   <= ena_n;
         frame <= frame_n;
         phase <= phase_n;
         dig   <= dig_n;
         ativo <= ativo_n;
      end
   end

   always_comb begin
      state_n = IDLE;
      presc_n = '0;
      idx_n   = 2'b00;
      ena_n   = 4'b0001;
      frame_n = '0;
      phase_n = 1'b0;
      dig_n   = 4'b0000;
      ativo_n = 1'b0;

      case (state)
         IDLE: begin
            if (erro_sensor) begin
               state_n = SCAN;
               dig_n   = 4'b0001;
               ativo_n = 1'b1;
            end
         end

         SCAN: begin
            // leaving on acknowledge overrides any pending advance
            if (!(ack && !erro_sensor)) begin
               state_n = SCAN;
               ativo_n = 1'b1;
               presc_n = presc + PW'(1);
               idx_n   = idx;
               ena_n   = ena;
               frame_n = frame;
               phase_n = phase;
               if (presc == PRESC_TC) begin
                  presc_n = '0;
                  idx_n   = idx + 2'd1;
                  ena_n   = {ena[2:0], ena[3]};
                  if (idx == 2'b11 && BLINK_FRAMES > 0) begin
                     if (frame == FRAME_TC) begin
                        frame_n = '0;
                        phase_n = ~phase;
                     end else begin
                        frame_n = frame + FW'(1);
                     end
                  end
               end
               dig_n = phase_n ? 4'b0000 : ena_n;
            end
         end

         default: state_n = IDLE;
      endcase
   end

   assign saida1Contador = idx[1];
   assign saida2Contador = idx[0];
   assign digito_en      = dig;
   assign erro_ativo     = ativo;

endmodule

// File: tb/tb_error_display_sequencer.sv
// Directed bench for error_display_sequencer with DIV_SCAN=4, BLINK_FRAMES=2.
module tb_error_display_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       erro_sensor;
   logic       ack;
   logic       saida1Contador;
   logic       saida2Contador;
   logic [3:0] digito_en;
   logic       erro_ativo;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   error_display_sequencer #(.DIV_SCAN(4), .BLINK_FRAMES(2)) dut (
      .clock          (clock),
      .reset          (reset),
      .erro_sensor    (erro_sensor),
      .ack            (ack),
      .saida1Contador (saida1Contador),
      .saida2Contador (saida2Contador),
      .digito_en      (digito_en),
      .erro_ativo     (erro_ativo)
   );

   always #5 clock = ~clock;

   localparam logic [6:0] IDLE_OUT = 7'b0_00_0000;

   // {erro_ativo, index, digito_en} expected c cycles after SCAN entry
   function automatic logic [6:0] exp_scan(input int c);
      int         i;
      int         ph;
      logic [1:0] ix;
      logic [3:0] en;
      i  = (c / 4) % 4;
      ph = (c / 32) % 2;
      ix = i[1:0];
      en = 4'b0001 << ix;
      if (ph != 0) en = 4'b0000;
      return {1'b1, ix, en};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [6:0] expv);
      logic [6:0] obs;
      obs   = {erro_ativo, saida1Contador, saida2Contador, digito_en};
      total = total + 1;
      assert (obs === expv) passed = passed + 1;
      else $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
   endtask

   initial begin
      reset       = 1'b1;
      erro_sensor = 1'b1;
      ack         = 1'b0;

      // reset wins over a present error
      step(); chk("reset_hold0", IDLE_OUT);
      step(); chk("reset_hold1", IDLE_OUT);
      reset = 1'b0;
      step(); cyc = 0; chk("entry", exp_scan(0));

      // two full frames lit, two frames dark, then lit again at index 00
      for (int k = 1; k <= 70; k++) begin
         step(); cyc = k; chk("scan_blink", exp_scan(cyc));
      end

      // ack while error still present is ignored
      ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(); cyc++; chk("ack_ignored", exp_scan(cyc));
      end
      erro_sensor = 1'b0;
      step(); chk("ack_exit", IDLE_OUT);
      step(); chk("idle_ack_ignored", IDLE_OUT);

      // exit coinciding with prescaler terminal count
      ack = 1'b0; erro_sensor = 1'b1;
      step(); cyc = 0; chk("reentry", exp_scan(0));
      erro_sensor = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step(); cyc = k; chk("latched_pre_tc", exp_scan(cyc));
      end
      ack = 1'b1;
      step(); chk("exit_at_tc", IDLE_OUT);

      // one-cycle error pulse stays latched without ack
      ack = 1'b0; erro_sensor = 1'b1;
      step(); cyc = 0; chk("pulse_entry", exp_scan(0));
      erro_sensor = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         step(); cyc = k; chk("pulse_latched", exp_scan(cyc));
      end
      ack = 1'b1;
      step(); chk("pulse_ack_exit", IDLE_OUT);
      ack = 1'b0;
      step(); chk("idle_quiet", IDLE_OUT);
      erro_sensor = 1'b1;
      step(); cyc = 0; chk("restart", exp_scan(0));

      // reset mid-scan at index 10 with blink phase 1
      for (int k = 1; k <= 40; k++) begin
         step(); cyc = k; chk("run_to_mid", exp_scan(cyc));
      end
      reset = 1'b1;
      step(); chk("mid_reset0", IDLE_OUT);
      step(); chk("mid_reset1", IDLE_OUT);
      reset = 1'b0;
      step(); cyc = 0; chk("post_reset_entry", exp_scan(0));
      for (int k = 1; k <= 6; k++) begin
         step(); cyc = k; chk("post_reset_scan", exp_scan(cyc));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/error_display_sequencer.md
Name: error_display_sequencer

Overview:
Generates the 2-bit character index (saida1Contador, saida2Contador) consumed by the error-message 7-segment letter decoder, plus one-hot digit enables for the multiplexed 4-digit display.
- Latches the sensor-SP error condition.
- Time-multiplexes the four character positions using an internal prescaler.
- Optionally blinks the whole message.
- Holds the message until the operator acknowledges after the error has cleared.

Parameters:
DIV_SCAN, 50000, clock cycles per character position; legal values ≥ 2. With a 50 MHz clock the default gives a 1 kHz digit rate.
BLINK_FRAMES, 250, complete 4-digit frames per blink phase; 0 disables blinking.

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
erro_sensor  input  1  level error flag from sensor SP supervision; 1 = error present
ack  input  1  operator acknowledge, level-sampled each cycle
saida1Contador  output  1  character index MSB, to the letter decoder
saida2Contador  output  1  character index LSB, to the letter decoder
digito_en  output  4  one-hot digit enable; bit0 = position 0; 0000 = display off
erro_ativo  output  1  1 while in state SCAN

Behaviour:
All outputs are registered. reset takes priority over every other input.

Reset values:
- state IDLE
- prescaler 0, index 00, frame counter 0, blink phase 0
- digito_en 0000
- erro_ativo 0

State IDLE:
- Index 00, digito_en 0000, erro_ativo 0.
- erro_sensor=1 sampled on an edge → SCAN on that edge.
- On entry to SCAN, in the same cycle: erro_ativo=1, index 00, digito_en 0001, prescaler 0, frame counter 0, blink phase 0.
- Latency is therefore 1 cycle from erro_sensor high to visible outputs.

State SCAN, prescaler and index:
- The prescaler increments every cycle.
- When prescaler = DIV_SCAN-1:
  - prescaler → 0
  - index → index+1 mod 4 (00→01→10→11→00)
  - internal enable rotates left (0001→0010→0100→1000→0001)
- Each index value is therefore held exactly DIV_SCAN cycles.
- Index and enable always stay aligned: index n ↔ internal enable bit n.

State SCAN, frame and blink:
- An advance from 11→00 ends a frame and increments the frame counter.
- If BLINK_FRAMES>0 and the frame counter = BLINK_FRAMES-1 at that wrap: blink phase toggles and the frame counter → 0.
- Blink phase 1: digito_en forced to 0000, while index, prescaler and internal rotation keep running.
- Blink phase 0: digito_en = internal enable.
- BLINK_FRAMES=0: phase stays 0 permanently.

State SCAN, exit:
- ack=1 and erro_sensor=0 → IDLE on the next edge, with all outputs at their reset values.
- ack=1 while erro_sensor=1 is ignored; the message persists.
- erro_sensor dropping without ack does not leave SCAN; the error stays latched.
- If exit coincides with a prescaler terminal count, exit wins and no advance is visible.
- In IDLE, ack is ignored.
- Re-entry to SCAN requires erro_sensor=1 again and restarts at index 00, enable 0001.

Widths:
- prescaler width = clog2(DIV_SCAN).
- frame counter width = clog2(BLINK_FRAMES+1), minimum 1 bit.
- No counter overflows: every counter is compared to its terminal value and cleared.

Invariants:
- digito_en is never multi-hot.
- In SCAN with phase 0, digito_en is exactly one-hot.

Test Plan:
1. Bench uses DIV_SCAN=4, BLINK_FRAMES=2. Pulse reset for 2 cycles with erro_sensor=1 held → outputs held at 00/0000/0 during reset; first post-reset edge gives erro_ativo=1, index 00, digito_en 0001.
2. Free-running SCAN → index sequence 00,01,10,11 each for exactly 4 cycles, with digito_en 0001,0010,0100,1000 aligned; wrap back to 00/0001 at cycle 16.
3. Blink: after 2 full frames (32 cycles) → digito_en 0000 for the next 32 cycles while the index keeps stepping; then enables return, aligned to the current index.
4. ack=1 with erro_sensor=1 → no change. Then erro_sensor=0 and ack=1 → next edge gives IDLE, 00/0000, erro_ativo=0. Repeat with ack coinciding with prescaler=3 → no index advance before IDLE.
5. erro_sensor pulses high for 1 cycle, then low, with no ack → SCAN persists indefinitely. Later, ack → IDLE. New erro_sensor pulse → restart at index 00, blink phase 0.
6. Assert reset mid-SCAN at index 10, blink phase 1 → next edge gives all reset values; with erro_sensor=1, SCAN restarts at 00/0001 on the first edge after reset is released.
